serial_adder: RTL and testbench
===============================

# serial_adder

Bit-serial WIDTH-bit adder that sits directly upstream of the team's `fulladder` cell and drives it. It accepts two operands plus carry-in over a valid/ready handshake and streams them LSB-first through one `fulladder` instance, one bit per clock. A carry flip-flop sits between bits. It returns the WIDTH-bit sum and carry-out over a second valid/ready handshake. It is the area-minimal adder for slow datapaths.

## Interface
- `WIDTH`, 8, operand/sum width in bits; legal range ≥ 2.
- `clk`  in  1  single clock; all state updates on rising edge.
- `rst_n`  in  1  reset; asynchronous, active-low.
- `in_valid`  in  1  upstream presents `a`, `b`, `cin`.
- `in_ready`  out  1  block can accept an operation; high only in IDLE.
- `a`  in  WIDTH  operand A.
- `b`  in  WIDTH  operand B.
- `cin`  in  1  carry-in into bit 0.
- `out_valid`  out  1  `sum`/`cout` hold a finished result.
- `out_ready`  in  1  downstream accepts the result.
- `sum`  out  WIDTH  result bits, registered.
- `cout`  out  1  carry out of bit WIDTH-1, registered.
- `busy`  out  1  high in RUN or DONE.

## Operation
- States: IDLE, RUN, DONE.
  - IDLE→RUN on `in_valid`.
  - RUN→DONE when bit WIDTH-1 is processed.
  - DONE→IDLE on `out_ready`.
- IDLE:
  - `in_ready`=1.
  - On `in_valid` at an edge, load `a_sh`←`a`, `b_sh`←`b`, `carry`←`cin`, `sum_sh`←0, `cnt`←0.
- RUN:
  - Each edge, the `fulladder` computes inputs (`a_sh[0]`, `b_sh[0]`, `carry`).
  - `sum_sh` ← {s, `sum_sh[WIDTH-1:1]`}.
  - `carry`←cy.
  - `a_sh` and `b_sh` shift right by 1.
  - `cnt`++.
  - At `cnt`==WIDTH-1 the same edge goes to DONE.
- DONE:
  - `out_valid`=1.
  - `sum`=`sum_sh` and `cout`=`carry`, held stable until handshake.
  - Leave on `out_ready` at an edge.
- Arithmetic:
  - {`cout`,`sum`} = `a` + `b` + `cin`, computed modulo 2^(WIDTH+1).
  - No signed interpretation; overflow is reported only via `cout`.
- `cnt` width is $clog2(WIDTH); it never wraps because the WIDTH-1 compare terminates RUN.
- `in_valid` in RUN/DONE is ignored, since `in_ready`=0. Upstream must hold its data until it sees `in_ready`.
- `out_ready` outside DONE is ignored.
- A DONE handshake and a new `in_valid` in the same cycle: the block returns to IDLE first. The new operation is accepted no earlier than the following edge.
- Reset:
  - Reset in any state immediately forces IDLE.
  - The in-flight operation is dropped; no partial result is emitted.
- Reset values: `in_ready`=1, `out_valid`=0, `sum`=0, `cout`=0, `busy`=0; all internal registers 0.

## Timing
- Input accepted at edge k; `out_valid` rises after edge k+WIDTH (WIDTH RUN cycles).
- Earliest next accept is edge k+WIDTH+2 when `out_ready` is held high: DONE one cycle, IDLE one cycle.
- Peak throughput is one operation per WIDTH+2 cycles.
- `in_ready`, `out_valid`, and `busy` decode combinationally from the state register only; there is no input-to-output combinational path.
- `sum`/`cout` change only on the load edge and on RUN edges; they are constant throughout DONE.

## Structure
- Shared package `serial_adder_pkg` holds:
  - state encoding localparams: IDLE=2'd0, RUN=2'd1, DONE=2'd2;
  - the default WIDTH.
- One sub-module: the existing `fulladder` (ports a, b, cin, s, cy), instantiated once and purely combinational.
- Remaining logic lives in the top module:
  - FSM;
  - `cnt`;
  - shift registers `a_sh`, `b_sh`, `sum_sh`;
  - `carry` flop.

## Test plan
- WIDTH=8: a=8'h00, b=8'h00, cin=0 -> sum=8'h00, cout=0; `out_valid` rises exactly 8 edges after accept.
- a=8'hFF, b=8'h01, cin=0 -> sum=8'h00, cout=1. Also a=8'hA5, b=8'h5A, cin=1 -> sum=8'h00, cout=1.
- a=8'h3C, b=8'h0F, cin=0 with `out_ready` held low 5 cycles in DONE -> sum=8'h4B, cout=0 stable throughout. `in_valid` pulses during RUN/DONE are ignored (`in_ready`=0).
- Back-to-back operations with `in_valid` and `out_ready` tied high -> accepts spaced exactly WIDTH+2 cycles apart; each result matches a+b+cin.
- Assert `rst_n`=0 at RUN cycle 3 -> `out_valid`=0, `sum`=0, `cout`=0, `in_ready`=1 immediately. A following operation 8'h12+8'h34 -> sum=8'h46, cout=0.
- Exhaustive WIDTH=2 sweep over all a, b, cin (32 cases) -> every result equals the reference sum.

Source files
------------

// File: rtl/serial_adder_pkg.sv
// serial_adder_pkg: state encoding and default width shared by the serial adder
package serial_adder_pkg;
    localparam int DEF_WIDTH = 8;
    localparam logic [1:0] IDLE = 2'd0;
    localparam logic [1:0] RUN  = 2'd1;
    localparam logic [1:0] DONE = 2'd2;
endpackage

// File: rtl/fulladder.sv
// fulladder: single-bit combinational full adder cell
module fulladder (
    input  logic a,
    input  logic b,
    input  logic cin,
    output logic s,
    output logic cy
);
    assign s  = a ^ b ^ cin;
    assign cy = (a & b) | (cin & (a ^ b));
endmodule

// File: rtl/serial_adder.sv
// serial_adder: bit-serial LSB-first adder, one bit per clock through a single fulladder
module serial_adder
    import serial_adder_pkg::*;
#(
    parameter int WIDTH = DEF_WIDTH
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] sum,
    output logic             cout,
    output logic             busy
);
    localparam int CW = $clog2(WIDTH);
    localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);
    logic [1:0]       state_q, state_d;
    logic [WIDTH-1:0] a_sh_q, a_sh_d, b_sh_q, b_sh_d, sum_sh_q, sum_sh_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic             carry_q, carry_d;
    logic             fa_s, fa_cy;

    fulladder u_fa (
        .a  (a_sh_q[0]),
        .b  (b_sh_q[0]),
        .cin(carry_q),
        .s  (fa_s),
        .cy (fa_cy)
    );

    assign in_ready  = state_q == IDLE;
    assign out_valid = state_q == DONE;
    assign busy      = (state_q == RUN) || (state_q == DONE);
    assign sum       = sum_sh_q;
    assign cout      = carry_q;

    always_comb begin
        state_d  = state_q;
        a_sh_d   = a_sh_q;
        b_sh_d   = b_sh_q;
        sum_sh_d = sum_sh_q;
        cnt_d    = cnt_q;
        carry_d  = carry_q;
        if (state_q == IDLE && in_valid) begin
            state_d  = RUN;
            a_sh_d   = a;
            b_sh_d   = b;
            carry_d  = cin;
            sum_sh_d = '0;
            cnt_d    = '0;
        end else if (state_q == RUN) begin
            state_d  = (cnt_q == LAST) ? DONE : RUN;
            a_sh_d   = a_sh_q >> 1;
            b_sh_d   = b_sh_q >> 1;
            sum_sh_d = {fa_s, sum_sh_q[WIDTH-1:1]};
            carry_d  = fa_cy;
            cnt_d    = cnt_q + CW'(1);
        end else if (state_q == DONE) begin
            state_d = out_ready ? IDLE : DONE;
        end else if (state_q != IDLE) begin
            state_d = IDLE;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= IDLE;
            a_sh_q   <= '0;
            b_sh_q   <= '0;
            sum_sh_q <= '0;
            cnt_q    <= '0;
            carry_q  <= 1'b0;
        end else begin
            state_q  <= state_d;
            a_sh_q   <= a_sh_d;
            b_sh_q   <= b_sh_d;
            sum_sh_q <= sum_sh_d;
            cnt_q    <= cnt_d;
            carry_q  <= carry_d;
        end
    end
endmodule

// File: tb/tb_serial_adder.sv
// tb_serial_adder: directed vector bench for serial_adder at WIDTH=8 and WIDTH=2
module tb_serial_adder;
    typedef struct {
        logic [7:0] a;
        logic [7:0] b;
        logic       cin;
        logic [7:0] sum;
        logic       cout;
    } vec_t;

    logic       clk, rst_n;
    logic       in_valid, in_ready, out_valid, out_ready, cin, cout, busy;
    logic [7:0] a, b, sum;
    logic       v2_in_valid, v2_in_ready, v2_out_valid, v2_out_ready, v2_cin, v2_cout, v2_busy;
    logic [1:0] v2_a, v2_b, v2_sum;
    int checks, failures;
    vec_t vecs[8];

    serial_adder #(.WIDTH(8)) dut (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
        .a(a), .b(b), .cin(cin), .out_valid(out_valid), .out_ready(out_ready),
        .sum(sum), .cout(cout), .busy(busy)
    );

    serial_adder #(.WIDTH(2)) dut2 (
        .clk(clk), .rst_n(rst_n), .in_valid(v2_in_valid), .in_ready(v2_in_ready),
        .a(v2_a), .b(v2_b), .cin(v2_cin), .out_valid(v2_out_valid), .out_ready(v2_out_ready),
        .sum(v2_sum), .cout(v2_cout), .busy(v2_busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h required=%0h", nm, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic run_op(input vec_t v, input string nm);
        int n;
        n = 0;
        while (!in_ready && n < 30) begin tick(); n++; end
        chk({nm, " in_ready"}, in_ready, 1);
        a = v.a; b = v.b; cin = v.cin; in_valid = 1'b1;
        tick();
        in_valid = 1'b0;
        chk({nm, " busy"}, busy, 1);
        n = 0;
        while (!out_valid && n < 20) begin tick(); n++; end
        chk({nm, " latency"}, n, 8);
        chk({nm, " sum"}, sum, v.sum);
        chk({nm, " cout"}, cout, v.cout);
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
        chk({nm, " back to idle"}, in_ready, 1);
    endtask

    task automatic run2(input logic [1:0] ta, input logic [1:0] tb2, input logic tc);
        int n;
        logic [2:0] ref3;
        ref3 = {1'b0, ta} + {1'b0, tb2} + {2'b00, tc};
        v2_a = ta; v2_b = tb2; v2_cin = tc; v2_in_valid = 1'b1;
        tick();
        v2_in_valid = 1'b0;
        n = 0;
        while (!v2_out_valid && n < 10) begin tick(); n++; end
        chk($sformatf("w2 latency %0d+%0d+%0d", ta, tb2, tc), n, 2);
        chk($sformatf("w2 result %0d+%0d+%0d", ta, tb2, tc), {v2_cout, v2_sum}, ref3);
        v2_out_ready = 1'b1;
        tick();
        v2_out_ready = 1'b0;
    endtask

    initial begin
        int last, got, ops, c;
        logic rdy;
        checks = 0; failures = 0;
        vecs[0] = '{8'h00, 8'h00, 1'b0, 8'h00, 1'b0};
        vecs[1] = '{8'hFF, 8'h01, 1'b0, 8'h00, 1'b1};
        vecs[2] = '{8'hA5, 8'h5A, 1'b1, 8'h00, 1'b1};
        vecs[3] = '{8'h3C, 8'h0F, 1'b0, 8'h4B, 1'b0};
        vecs[4] = '{8'h12, 8'h34, 1'b0, 8'h46, 1'b0};
        vecs[5] = '{8'h80, 8'h80, 1'b1, 8'h01, 1'b1};
        vecs[6] = '{8'h7F, 8'h01, 1'b0, 8'h80, 1'b0};
        vecs[7] = '{8'hFF, 8'hFF, 1'b1, 8'hFF, 1'b1};
        in_valid = 0; out_ready = 0; a = 0; b = 0; cin = 0;
        v2_in_valid = 0; v2_out_ready = 0; v2_a = 0; v2_b = 0; v2_cin = 0;
        rst_n = 1'b0;
        tick(); tick();
        chk("reset in_ready", in_ready, 1);
        chk("reset out_valid", out_valid, 0);
        chk("reset busy", busy, 0);
        chk("reset sum", sum, 0);
        chk("reset cout", cout, 0);
        rst_n = 1'b1;
        tick();

        for (int i = 0; i < 8; i++) run_op(vecs[i], $sformatf("vec%0d", i));

        // stall in DONE with stray in_valid requests throughout
        a = 8'h3C; b = 8'h0F; cin = 1'b0; in_valid = 1'b1;
        tick();
        a = 8'hFF; b = 8'hFF; cin = 1'b1;
        for (int i = 0; i < 8; i++) begin
            chk("hold run in_ready", in_ready, 0);
            tick();
        end
        for (int i = 0; i < 5; i++) begin
            chk("hold out_valid", out_valid, 1);
            chk("hold sum", sum, 8'h4B);
            chk("hold cout", cout, 0);
            chk("hold in_ready", in_ready, 0);
            tick();
        end
        in_valid = 1'b0; out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
        chk("hold released idle", in_ready, 1);
        tick();
        chk("hold no stray accept", busy, 0);

        // back-to-back with in_valid and out_ready tied high
        last = -1; got = 0; ops = 0;
        in_valid = 1'b1; out_ready = 1'b1;
        for (c = 0; c < 60 && got < 3; c++) begin
            if (out_valid) begin
                chk($sformatf("b2b sum %0d", got), sum, vecs[got].sum);
                chk($sformatf("b2b cout %0d", got), cout, vecs[got].cout);
                got++;
            end
            rdy = in_ready;
            if (rdy) begin
                if (last >= 0) chk("b2b spacing", c - last, 10);
                last = c;
                a = vecs[ops % 8].a; b = vecs[ops % 8].b; cin = vecs[ops % 8].cin;
                ops++;
            end
            tick();
        end
        chk("b2b results seen", got, 3);
        in_valid = 1'b0; out_ready = 1'b0;

        // async reset in the middle of RUN
        rst_n = 1'b0; #2; rst_n = 1'b1;
        tick();
        a = 8'hFF; b = 8'hFF; cin = 1'b1; in_valid = 1'b1;
        tick();
        in_valid = 1'b0;
        tick(); tick(); tick();
        chk("pre-reset sum partial", sum, 8'hE0);
        rst_n = 1'b0;
        #1;
        chk("mid reset out_valid", out_valid, 0);
        chk("mid reset sum", sum, 0);
        chk("mid reset cout", cout, 0);
        chk("mid reset in_ready", in_ready, 1);
        chk("mid reset busy", busy, 0);
        tick();
        rst_n = 1'b1;
        tick();
        run_op(vecs[4], "post-reset");

        for (int x = 0; x < 32; x++) run2(x[4:3], x[2:1], x[0]);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
